// File: rtl/mult_share_arb.sv
// Round-robin sharing of one pipelined valid/ready multiplier between NUM_REQ requesters,
// with ID tagging, in-order result routing and credit limiting. Define MULT_SHARE_ARB_STATS_EN for grant/stall counters.
module mult_share_arb #(
  parameter int NUM_REQ      = 2,
  parameter int DAT_BITS     = 256,
  parameter int CTL_BITS     = 8,
  parameter int MAX_INFLIGHT = 16,
  parameter int ID_BITS      = $clog2(NUM_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req_val,
  input  logic [NUM_REQ*2*DAT_BITS-1:0] i_req_dat,
  input  logic [NUM_REQ*CTL_BITS-1:0]   i_req_ctl,
  output logic [NUM_REQ-1:0]            o_req_rdy,
  output logic                          o_mul_val,
  output logic [2*DAT_BITS-1:0]         o_mul_dat,
  output logic [CTL_BITS+ID_BITS-1:0]   o_mul_ctl,
  input  logic                          i_mul_rdy,
  input  logic                          i_mul_val,
  input  logic [2*DAT_BITS-1:0]         i_mul_dat,
  input  logic [CTL_BITS+ID_BITS-1:0]   i_mul_ctl,
  output logic                          o_mul_rdy,
  output logic [NUM_REQ-1:0]            o_rsp_val,
  output logic [2*DAT_BITS-1:0]         o_rsp_dat,
  output logic [CTL_BITS-1:0]           o_rsp_ctl,
  input  logic [NUM_REQ-1:0]            i_rsp_rdy,
  output logic                          o_busy,
  output logic                          o_err
`ifdef MULT_SHARE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]         o_grant_cnt,
  output logic [31:0]                   o_stall_cnt
`endif
);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0]   MAX_CNT = CNT_W'(MAX_INFLIGHT);
  localparam logic [ID_BITS-1:0] LAST_ID = ID_BITS'(NUM_REQ - 1);

  logic                        mul_val_q, mul_val_d;
  logic [2*DAT_BITS-1:0]       mul_dat_q, mul_dat_d;
  logic [CTL_BITS+ID_BITS-1:0] mul_ctl_q, mul_ctl_d;
  logic [ID_BITS-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]            inflight_q, inflight_d;
  logic                        err_q, err_d;

  logic               loadable, can_issue, gnt_found, req_hs, rsp_hs, id_ok, credit_ret;
  logic [ID_BITS-1:0] gnt_idx, rsp_id;
  logic [NUM_REQ-1:0] id_hit;

  assign loadable  = ~mul_val_q | i_mul_rdy;
  assign can_issue = loadable & (inflight_q < MAX_CNT);
  assign req_hs    = can_issue & gnt_found;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [ID_BITS-1:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = (int'(rr_ptr_q) + off >= NUM_REQ) ? ID_BITS'(int'(rr_ptr_q) + off - NUM_REQ)
                                                : ID_BITS'(int'(rr_ptr_q) + off);
      if (!gnt_found && i_req_val[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign rsp_id = i_mul_ctl[CTL_BITS +: ID_BITS];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
    assign o_req_rdy[gi] = req_hs & (gnt_idx == ID_BITS'(gi));
    assign id_hit[gi]    = (rsp_id == ID_BITS'(gi));
    assign o_rsp_val[gi] = i_mul_val & id_hit[gi];
  end

  // A tag that matches no requester is accepted and dropped so the pipe never wedges.
  assign id_ok      = |id_hit;
  assign o_mul_rdy  = ~id_ok | (|(i_rsp_rdy & id_hit));
  assign rsp_hs     = i_mul_val & o_mul_rdy;
  assign credit_ret = rsp_hs & (inflight_q != '0);
  assign o_rsp_dat  = i_mul_dat;
  assign o_rsp_ctl  = i_mul_ctl[CTL_BITS-1:0];

  always_comb begin
    mul_val_d  = mul_val_q;
    mul_dat_d  = mul_dat_q;
    mul_ctl_d  = mul_ctl_q;
    rr_ptr_d   = rr_ptr_q;
    inflight_d = inflight_q;
    err_d      = err_q;
    if (loadable) begin
      mul_val_d = req_hs;
      if (req_hs) begin
        mul_dat_d = i_req_dat[int'(gnt_idx)*2*DAT_BITS +: 2*DAT_BITS];
        mul_ctl_d = {gnt_idx, i_req_ctl[int'(gnt_idx)*CTL_BITS +: CTL_BITS]};
      end
    end
    if (req_hs) begin
      rr_ptr_d = (gnt_idx == LAST_ID) ? '0 : gnt_idx + ID_BITS'(1);
    end
    case ({req_hs, credit_ret})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
    if (i_mul_val & (~id_ok | (inflight_q == '0))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mul_val_q  <= 1'b0;
      mul_dat_q  <= '0;
      mul_ctl_q  <= '0;
      rr_ptr_q   <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      mul_val_q  <= mul_val_d;
      mul_dat_q  <= mul_dat_d;
      mul_ctl_q  <= mul_ctl_d;
      rr_ptr_q   <= rr_ptr_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign o_mul_val = mul_val_q;
  assign o_mul_dat = mul_dat_q;
  assign o_mul_ctl = mul_ctl_q;
  assign o_busy    = (inflight_q != '0);
  assign o_err     = err_q;

`ifdef MULT_SHARE_ARB_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt_d = stall_cnt_q + 32'((|i_req_val) & ~(|o_req_rdy));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;

  // o_req_rdy is only raised toward a valid requester, so it marks a handshake.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gcnt
    logic [31:0] gcnt_q, gcnt_d;

    assign gcnt_d = gcnt_q + 32'(o_req_rdy[gi]);

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        gcnt_q <= '0;
      end else begin
        gcnt_q <= gcnt_d;
      end
    end

    assign o_grant_cnt[gi*32 +: 32] = gcnt_q;
  end
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb: reset-state vector table, directed corner sequences,
// and a randomized run checked against a queue-based transaction model.
module tb_mult_share_arb;
  localparam int NR = 2;
  localparam int DW = 16;
  localparam int CW = 8;
  localparam int MI = 4;
  localparam int IB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               i_rst_n;
  logic [NR-1:0]      i_req_val;
  logic [NR*2*DW-1:0] i_req_dat;
  logic [NR*CW-1:0]   i_req_ctl;
  logic [NR-1:0]      o_req_rdy;
  logic               o_mul_val;
  logic [2*DW-1:0]    o_mul_dat;
  logic [CW+IB-1:0]   o_mul_ctl;
  logic               i_mul_rdy;
  logic               i_mul_val;
  logic [2*DW-1:0]    i_mul_dat;
  logic [CW+IB-1:0]   i_mul_ctl;
  logic               o_mul_rdy;
  logic [NR-1:0]      o_rsp_val;
  logic [2*DW-1:0]    o_rsp_dat;
  logic [CW-1:0]      o_rsp_ctl;
  logic [NR-1:0]      i_rsp_rdy;
  logic               o_busy;
  logic               o_err;

  mult_share_arb #(
    .NUM_REQ(NR), .DAT_BITS(DW), .CTL_BITS(CW), .MAX_INFLIGHT(MI)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_req_val(i_req_val), .i_req_dat(i_req_dat), .i_req_ctl(i_req_ctl), .o_req_rdy(o_req_rdy),
    .o_mul_val(o_mul_val), .o_mul_dat(o_mul_dat), .o_mul_ctl(o_mul_ctl), .i_mul_rdy(i_mul_rdy),
    .i_mul_val(i_mul_val), .i_mul_dat(i_mul_dat), .i_mul_ctl(i_mul_ctl), .o_mul_rdy(o_mul_rdy),
    .o_rsp_val(o_rsp_val), .o_rsp_dat(o_rsp_dat), .o_rsp_ctl(o_rsp_ctl), .i_rsp_rdy(i_rsp_rdy),
    .o_busy(o_busy), .o_err(o_err)
  );

  typedef struct {
    logic [31:0] prod;
    logic [8:0]  ctl;
    int          due;
  } mres_t;

  typedef struct {
    int          id;
    logic [31:0] dat;
    logic [7:0]  ctl;
  } txn_t;

  typedef struct {
    logic [1:0] rv;
    logic       mv;
    logic       id;
    logic [1:0] rr;
    logic [1:0] e_rdy;
    logic [1:0] e_rv;
    logic       e_mrdy;
  } vec_t;

  int    n_pass = 0;
  int    n_total = 0;
  int    cyc = 0;
  int    n_hs = 0;
  bit    mm_en = 1'b0;
  bit    hold_req = 1'b0;
  mres_t mq[$];
  txn_t  got_q[$];
  txn_t  ord_q[$];
  vec_t  tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic set_req(input int k, input logic [15:0] a, input logic [15:0] b, input logic [7:0] c);
    i_req_dat[k*32 +: 32] = {b, a};
    i_req_ctl[k*8 +: 8]   = c;
    i_req_val[k]          = 1'b1;
  endtask

  // One clock; also runs the 5-cycle in-order multiplier model when mm_en is set.
  task automatic step();
    logic        iss, ret;
    logic [31:0] d, p;
    logic [8:0]  c;
    iss = o_mul_val & i_mul_rdy;
    ret = i_mul_val & o_mul_rdy;
    d   = o_mul_dat;
    c   = o_mul_ctl;
    @(posedge clk);
    #1;
    cyc++;
    if (mm_en) begin
      if (ret && mq.size() > 0) mq.delete(0);
      if (iss) begin
        p = 32'(d[15:0]) * 32'(d[31:16]);
        mq.push_back('{prod: p, ctl: c, due: cyc + 5});
      end
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        i_mul_val = 1'b1;
        i_mul_dat = mq[0].prod;
        i_mul_ctl = mq[0].ctl;
      end else begin
        i_mul_val = 1'b0;
      end
    end
  endtask

  task automatic run(input int n);
    logic [NR-1:0] hs;
    for (int i = 0; i < n; i++) begin
      #1;
      hs = i_req_val & o_req_rdy;
      n_hs += $countones(hs);
      for (int k = 0; k < NR; k++) begin
        if (o_rsp_val[k] && i_rsp_rdy[k]) got_q.push_back('{id: k, dat: o_rsp_dat, ctl: o_rsp_ctl});
      end
      step();
      if (!hold_req) i_req_val = i_req_val & ~hs;
    end
  endtask

  task automatic do_reset();
    i_rst_n   = 1'b0;
    i_req_val = '0;
    i_mul_rdy = 1'b0;
    i_mul_val = 1'b0;
    i_mul_dat = '0;
    i_mul_ctl = '0;
    i_rsp_rdy = '0;
    step();
    i_rst_n   = 1'b1;
    mq.delete();
    got_q.delete();
    i_mul_val = 1'b0;
    n_hs      = 0;
  endtask

  task automatic chk_got(input string name, input int idx, input int id, input logic [31:0] dat, input logic [7:0] c);
    if (got_q.size() > idx) begin
      chk({name, "_id"}, 64'(got_q[idx].id), 64'(id));
      chk({name, "_dat"}, got_q[idx].dat, dat);
      chk({name, "_ctl"}, got_q[idx].ctl, c);
    end
  endtask

  initial begin
    logic [15:0] ra[NR];
    logic [15:0] rb[NR];
    logic [7:0]  rc[NR];
    int          m_rr, m_inf, g, hid;
    logic        m_val, loadable, ret;
    logic [31:0] m_dat;
    logic [8:0]  m_ctl;

    i_rst_n = 1'b0; i_req_val = '0; i_req_dat = '0; i_req_ctl = '0;
    i_mul_rdy = 1'b0; i_mul_val = 1'b0; i_mul_dat = '0; i_mul_ctl = '0; i_rsp_rdy = '0;
    step();
    step();
    chk("reset_mul_val", o_mul_val, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_err", o_err, 0);

    // Combinational grant and routing from the reset state, reset held low.
    tbl[0] = '{2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1};
    tbl[1] = '{2'b01, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0};
    tbl[2] = '{2'b10, 1'b1, 1'b0, 2'b01, 2'b10, 2'b01, 1'b1};
    tbl[3] = '{2'b11, 1'b1, 1'b1, 2'b01, 2'b01, 2'b10, 1'b0};
    tbl[4] = '{2'b11, 1'b1, 1'b1, 2'b10, 2'b01, 2'b10, 1'b1};
    tbl[5] = '{2'b00, 1'b1, 1'b0, 2'b10, 2'b00, 2'b01, 1'b0};
    tbl[6] = '{2'b10, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 1'b1};
    tbl[7] = '{2'b01, 1'b1, 1'b1, 2'b11, 2'b01, 2'b10, 1'b1};
    for (int i = 0; i < 8; i++) begin
      i_req_val = tbl[i].rv;
      i_mul_val = tbl[i].mv;
      i_mul_ctl = {tbl[i].id, 8'(i * 17 + 3)};
      i_mul_dat = $urandom;
      i_rsp_rdy = tbl[i].rr;
      #1;
      chk($sformatf("tbl%0d_req_rdy", i), o_req_rdy, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_rsp_val", i), o_rsp_val, tbl[i].e_rv);
      chk($sformatf("tbl%0d_mul_rdy", i), o_mul_rdy, tbl[i].e_mrdy);
      chk($sformatf("tbl%0d_rsp_dat", i), o_rsp_dat, i_mul_dat);
      chk($sformatf("tbl%0d_rsp_ctl", i), o_rsp_ctl, 8'(i * 17 + 3));
      step();
    end

    // Fairness: both requesting, grants alternate 0,1,0,1.
    do_reset();
    mm_en = 1'b0;
    i_mul_rdy = 1'b1;
    set_req(0, 16'd1, 16'd1, 8'h01);
    set_req(1, 16'd2, 16'd2, 8'h02);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("fair%0d_rdy", i), o_req_rdy, (i % 2 == 0) ? 2'b01 : 2'b10);
      step();
      chk($sformatf("fair%0d_mul_val", i), o_mul_val, 1);
      chk($sformatf("fair%0d_id", i), o_mul_ctl[8], i % 2);
    end

    // Routing through a 5-cycle multiplier.
    do_reset();
    mm_en = 1'b1;
    i_mul_rdy = 1'b1;
    i_rsp_rdy = 2'b11;
    set_req(0, 16'd3, 16'd5, 8'hA1);
    set_req(1, 16'd7, 16'd11, 8'hB2);
    run(15);
    chk("route_count", got_q.size(), 2);
    chk_got("route0", 0, 0, 32'd15, 8'hA1);
    chk_got("route1", 1, 1, 32'd77, 8'hB2);

    // Credit limit: results held off.
    do_reset();
    mm_en = 1'b0;
    i_mul_rdy = 1'b1;
    hold_req = 1'b1;
    set_req(0, 16'd4, 16'd4, 8'h44);
    run(8);
    chk("credit_hs", n_hs, MI);
    #1;
    chk("credit_full_rdy", o_req_rdy, 2'b00);
    chk("credit_full_busy", o_busy, 1);
    i_mul_val = 1'b1;
    i_mul_ctl = {1'b0, 8'h44};
    i_mul_dat = 32'd16;
    i_rsp_rdy = 2'b01;
    #1;
    chk("credit_ret_mul_rdy", o_mul_rdy, 1);
    chk("credit_ret_same_cycle", o_req_rdy, 2'b00);
    step();
    i_mul_val = 1'b0;
    #1;
    chk("credit_regrant", o_req_rdy, 2'b01);
    step();
    #1;
    chk("credit_refull", o_req_rdy, 2'b00);
    hold_req = 1'b0;

    // Backpressure on the issue register.
    do_reset();
    mm_en = 1'b0;
    set_req(0, 16'd1, 16'd2, 8'h21);
    #1;
    chk("bp_first_rdy", o_req_rdy, 2'b01);
    step();
    i_req_val[0] = 1'b0;
    set_req(1, 16'd9, 16'd4, 8'h33);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp%0d_rdy", i), o_req_rdy, 2'b00);
      chk($sformatf("bp%0d_dat", i), o_mul_dat, 32'h0002_0001);
      chk($sformatf("bp%0d_ctl", i), o_mul_ctl, {1'b0, 8'h21});
      step();
    end
    i_mul_rdy = 1'b1;
    #1;
    chk("bp_release_rdy", o_req_rdy, 2'b10);
    step();
    chk("bp_next_dat", o_mul_dat, 32'h0004_0009);
    chk("bp_next_ctl", o_mul_ctl, {1'b1, 8'h33});

    // Response stall: requester 0 not ready blocks requester 1's result.
    do_reset();
    mm_en = 1'b1;
    i_mul_rdy = 1'b1;
    i_rsp_rdy = 2'b10;
    set_req(0, 16'd4, 16'd6, 8'h11);
    set_req(1, 16'd5, 16'd5, 8'h22);
    run(12);
    #1;
    chk("stall_none_out", got_q.size(), 0);
    chk("stall_rsp_val", o_rsp_val, 2'b01);
    chk("stall_mul_rdy", o_mul_rdy, 0);
    i_rsp_rdy = 2'b11;
    run(6);
    chk("stall_drain_count", got_q.size(), 2);
    chk_got("stall0", 0, 0, 32'd24, 8'h11);
    chk_got("stall1", 1, 1, 32'd25, 8'h22);

    // Orphan result sets the sticky error.
    do_reset();
    mm_en = 1'b0;
    i_rsp_rdy = 2'b11;
    i_mul_val = 1'b1;
    i_mul_ctl = {1'b0, 8'h55};
    #1;
    chk("err_before", o_err, 0);
    step();
    i_mul_val = 1'b0;
    #1;
    chk("err_set", o_err, 1);
    chk("err_busy", o_busy, 0);
    step();
    step();
    chk("err_sticky", o_err, 1);

    // Reset in the middle of traffic.
    mm_en = 1'b1;
    i_mul_rdy = 1'b1;
    hold_req = 1'b1;
    set_req(0, 16'd2, 16'd3, 8'h61);
    set_req(1, 16'd4, 16'd5, 8'h62);
    run(3);
    i_rst_n = 1'b0;
    #1;
    step();
    i_rst_n = 1'b1;
    mq.delete();
    i_mul_val = 1'b0;
    #1;
    chk("rst_err", o_err, 0);
    chk("rst_mul_val", o_mul_val, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_grant0", o_req_rdy, 2'b01);
    hold_req = 1'b0;

    // Randomized traffic against a transaction-level model.
    do_reset();
    mm_en = 1'b1;
    ord_q.delete();
    m_rr = 0; m_inf = 0; m_val = 1'b0; m_dat = '0; m_ctl = '0;
    for (int t = 0; t < 600; t++) begin
      for (int k = 0; k < NR; k++) begin
        if (!i_req_val[k] && $urandom_range(0, 2) == 0) begin
          ra[k] = 16'($urandom);
          rb[k] = 16'($urandom);
          rc[k] = 8'($urandom);
          set_req(k, ra[k], rb[k], rc[k]);
        end
        i_rsp_rdy[k] = ($urandom_range(0, 3) != 0);
      end
      i_mul_rdy = ($urandom_range(0, 3) != 0);
      #1;
      loadable = !m_val || i_mul_rdy;
      g = -1;
      if (loadable && m_inf < MI) begin
        for (int off = 0; off < NR; off++) begin
          if (g < 0 && i_req_val[(m_rr + off) % NR]) g = (m_rr + off) % NR;
        end
      end
      chk("rnd_req_rdy", o_req_rdy, (g >= 0) ? 64'(1 << g) : 64'd0);
      chk("rnd_mul_val", o_mul_val, m_val);
      if (m_val) begin
        chk("rnd_mul_dat", o_mul_dat, m_dat);
        chk("rnd_mul_ctl", o_mul_ctl, m_ctl);
      end
      chk("rnd_busy", o_busy, m_inf != 0);
      ret = 1'b0;
      if (i_mul_val && ord_q.size() > 0) begin
        hid = ord_q[0].id;
        chk("rnd_rsp_val", o_rsp_val, 64'(1 << hid));
        chk("rnd_mul_rdy", o_mul_rdy, i_rsp_rdy[hid]);
        ret = i_rsp_rdy[hid];
        if (ret) begin
          chk("rnd_rsp_dat", o_rsp_dat, ord_q[0].dat);
          chk("rnd_rsp_ctl", o_rsp_ctl, ord_q[0].ctl);
        end
      end else begin
        chk("rnd_rsp_idle", o_rsp_val, 2'b00);
      end
      if (ret) begin
        ord_q.delete(0);
        m_inf--;
      end
      if (g >= 0) begin
        ord_q.push_back('{id: g, dat: 32'(ra[g]) * 32'(rb[g]), ctl: rc[g]});
        m_inf++;
        m_rr = (g + 1) % NR;
      end
      if (loadable) begin
        m_val = (g >= 0);
        if (g >= 0) begin
          m_dat = {rb[g], ra[g]};
          m_ctl = {1'(g), rc[g]};
        end
      end
      step();
      if (g >= 0) i_req_val[g] = 1'b0;
    end
    #1;
    chk("rnd_no_err", o_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Round-robin arbiter that shares one pipelined multiplier (2-operand, AXI-stream style valid/ready) between NUM_REQ requesters, e.g. the stage-1 and stage-2 multiplies of several Barrett reduction pipes.
- Tags each issued operation with the requester ID in extra ctl bits.
- Routes in-order multiplier results back to the owning requester.
- Bounds in-flight operations with a credit counter.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- DAT_BITS, 256, operand width; request dat is {b, a}, a in [DAT_BITS-1:0].
- CTL_BITS, 8, requester ctl width, returned unchanged.
- MAX_INFLIGHT, 16, maximum operations accepted and not yet returned.
- ID_BITS, $clog2(NUM_REQ), derived, width of the tag.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_req_val  in  NUM_REQ  per-requester request valid
- i_req_dat  in  NUM_REQ*2*DAT_BITS  per-requester {b,a}
- i_req_ctl  in  NUM_REQ*CTL_BITS  per-requester ctl
- o_req_rdy  out  NUM_REQ  per-requester ready (at most one bit high)
- o_mul_val  out  1  multiplier operand valid
- o_mul_dat  out  2*DAT_BITS  operands {b,a}
- o_mul_ctl  out  CTL_BITS+ID_BITS  {id, ctl}
- i_mul_rdy  in  1  multiplier accepts operands
- i_mul_val  in  1  multiplier result valid
- i_mul_dat  in  2*DAT_BITS  product
- i_mul_ctl  in  CTL_BITS+ID_BITS  {id, ctl} echoed by multiplier
- o_mul_rdy  out  1  ready back to multiplier result port
- o_rsp_val  out  NUM_REQ  per-requester result valid
- o_rsp_dat  out  2*DAT_BITS  product, broadcast to all requesters
- o_rsp_ctl  out  CTL_BITS  ctl, broadcast
- i_rsp_rdy  in  NUM_REQ  per-requester result ready
- o_busy  out  1  inflight != 0
- o_err  out  1  sticky protocol error

Behaviour:
- Reset (i_rst_n low at a clock edge): o_mul_val=0, inflight=0, rr_ptr=0, o_err=0; o_req_rdy, o_rsp_val, o_mul_rdy follow combinationally from the reset state. Reset mid-operation discards the issue register and all credits; results still in the multiplier after reset are the integrator's responsibility.
- Issue register: loads when (~o_mul_val | i_mul_rdy). Otherwise it holds o_mul_val, o_mul_dat and o_mul_ctl stable.
- can_issue = issue register loadable and inflight < MAX_INFLIGHT.
- Grant (combinational): when can_issue, first k with i_req_val[k]=1, searching k = rr_ptr, rr_ptr+1, ... modulo NUM_REQ. o_req_rdy[k]=1 for that k only; all other o_req_rdy are 0. When !can_issue, o_req_rdy=0.
- On request handshake from k:
  - o_mul_val<=1, o_mul_dat<=i_req_dat[k], o_mul_ctl<={k, i_req_ctl[k]}.
  - rr_ptr<=(k+1) mod NUM_REQ.
- If the register is loadable and no request is granted, o_mul_val<=0.
- Latency: request handshake in cycle N gives o_mul_val=1 in N+1.
- Result return (combinational, zero latency):
  - id = i_mul_ctl[CTL_BITS +: ID_BITS].
  - o_rsp_val[id]=i_mul_val; all other o_rsp_val are 0.
  - o_rsp_dat=i_mul_dat; o_rsp_ctl=i_mul_ctl[CTL_BITS-1:0].
  - o_mul_rdy=i_rsp_rdy[id].
  - Head-of-line blocking by a stalled requester is accepted by design.
- Credits: inflight +1 on request handshake, -1 on result handshake (i_mul_val & o_mul_rdy). Both in the same cycle leaves it unchanged. A retiring result does not free a credit in the same cycle.
- Boundaries:
  - inflight==MAX_INFLIGHT: o_req_rdy all 0.
  - id >= NUM_REQ (non-power-of-2 NUM_REQ): no o_rsp_val, o_mul_rdy=1 (drop), o_err<=1.
  - Result valid while inflight==0: o_err<=1, counter stays 0.
  - o_err clears only on reset.

Optional Feature:
- Macro: MULT_SHARE_ARB_STATS_EN.
- With the macro defined:
  - Adds output o_grant_cnt, NUM_REQ*32 bits, one 32-bit counter per requester.
  - Counter k increments on each request handshake from k, wraps at 2^32, resets to 0.
  - Adds output o_stall_cnt, 32 bits, incrementing each cycle with any i_req_val high and o_req_rdy all 0.
- Without the macro: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Fairness: NUM_REQ=2, both i_req_val held 1, i_mul_rdy=1 -> grants alternate 0,1,0,1 from reset; o_mul_ctl id field matches each grant.
- Routing: multiplier model with 5-cycle latency; req0 a=3,b=5 and req1 a=7,b=11 -> o_rsp_val[0] with dat 15, then o_rsp_val[1] with dat 77; ctl returned unchanged.
- Credit limit: MAX_INFLIGHT=4, results held off -> exactly 4 handshakes, then o_req_rdy=0 and o_busy=1. Releasing one result allows one new grant on the following cycle.
- Backpressure: i_mul_rdy=0 for 3 cycles with o_mul_val=1 -> o_mul_dat/ctl stable, o_req_rdy=0. Then i_mul_rdy=1 -> next grant lands the same cycle.
- Response stall: i_rsp_rdy[0]=0 with a req0 result at the head -> o_mul_rdy=0 and the req1 result waits; raising i_rsp_rdy[0] drains both in order.
- Errors and reset: inject a result with inflight=0 -> o_err=1 sticky. Drive i_rst_n=0 for one cycle mid-traffic -> o_err=0, o_mul_val=0, o_busy=0, and the next grant goes to requester 0.
